// File: rtl/matrix_op_sequencer.sv
// Whole-matrix command sequencer: expands one command into the coprocessor's
// store / exec / load instruction stream and reassembles the 200-bit result.
module matrix_op_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [3:0]   i_cmd_op,
  input  logic [1:0]   i_cmd_msize,
  input  logic [199:0] i_cmd_mat_a,
  input  logic [199:0] i_cmd_mat_b,
  output logic [31:0]  o_cop_instr,
  input  logic [31:0]  i_cop_data,
  input  logic         i_cop_ready,
  input  logic         i_cop_ovf,
  output logic         o_res_valid,
  output logic [199:0] o_result,
  output logic         o_ovf,
  output logic         o_err,
  output logic         o_busy
);

  localparam int unsigned MAT_W  = 200;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] OPC_STORE_A    = 4'd7;
  localparam logic [3:0] OPC_STORE_B    = 4'd8;
  localparam logic [3:0] OPC_LOAD       = 4'd9;
  localparam logic [3:0] OP_INT_MULT    = 4'd3;
  localparam logic [3:0] OP_MAX         = 4'd6;
  localparam logic [3:0] LAST_STORE_POS = 4'd12;
  localparam logic [3:0] LAST_LOAD_POS  = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {P_STORE_A, P_STORE_B, P_EXEC, P_LOAD} phase_t;

  state_t             r_state, w_state_nxt;
  phase_t             r_phase, w_phase_nxt;
  logic [3:0]         r_pos, w_pos_nxt;
  logic [3:0]         r_op, w_op;
  logic [1:0]         r_msize, w_msize;
  logic [MAT_W-1:0]   r_mat_a, w_mat_a;
  logic [MAT_W-1:0]   r_mat_b, w_mat_b;
  logic [CNT_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [MAT_W-1:0]   r_stage, w_stage_nxt;
  logic               r_ovf_stage, w_ovf_stage_nxt;
  logic               w_done_ok, w_done_err;
  logic [DATA_W-1:0]  w_data;
  logic [3:0]         w_opc;
  logic [31:0]        w_instr_nxt;

  // Two matrix elements per store word; the 25th element shares its word with zero.
  function automatic logic [DATA_W-1:0] store_data(input logic [MAT_W-1:0] mat,
                                                   input logic [3:0] pos);
    logic [DATA_W-1:0] d;
    d = {mat[7:0], 8'h00};
    for (int k = 0; k < 12; k++) begin
      if (pos == 4'(k)) d = mat[MAT_W-1-16*k -: 16];
    end
    return d;
  endfunction

  always_comb begin : next_state
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_pos_nxt       = r_pos;
    w_wcnt_nxt      = r_wcnt;
    w_stage_nxt     = r_stage;
    w_ovf_stage_nxt = r_ovf_stage;
    w_op            = r_op;
    w_msize         = r_msize;
    w_mat_a         = r_mat_a;
    w_mat_b         = r_mat_b;
    w_done_ok       = 1'b0;
    w_done_err      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_op        = i_cmd_op;
          w_msize     = i_cmd_msize;
          w_mat_a     = i_cmd_mat_a;
          w_mat_b     = i_cmd_mat_b;
          w_phase_nxt = P_STORE_A;
          w_pos_nxt   = '0;
          if (i_cmd_op > OP_MAX) begin
            w_state_nxt = S_DONE;
            w_done_err  = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_wcnt_nxt  = '0;
      end
      S_WAIT: begin
        if (i_cop_ready) begin
          w_state_nxt = S_ISSUE;
          w_pos_nxt   = r_pos + 4'd1;
          case (r_phase)
            P_STORE_A: begin
              if (r_pos == LAST_STORE_POS) begin
                w_pos_nxt   = '0;
                w_phase_nxt = (r_op <= OP_INT_MULT) ? P_STORE_B : P_EXEC;
              end
            end
            P_STORE_B: begin
              if (r_pos == LAST_STORE_POS || r_op == OP_INT_MULT) begin
                w_pos_nxt   = '0;
                w_phase_nxt = P_EXEC;
              end
            end
            P_EXEC: begin
              w_ovf_stage_nxt = i_cop_ovf;
              w_pos_nxt       = '0;
              w_phase_nxt     = P_LOAD;
            end
            default: begin
              // Load beats land in a staging copy so an abort never disturbs o_result.
              for (int k = 0; k < 6; k++) begin
                if (r_pos == 4'(k)) w_stage_nxt[MAT_W-1-32*k -: 32] = i_cop_data;
              end
              if (r_pos == LAST_LOAD_POS) begin
                w_stage_nxt[7:0] = i_cop_data[31:24];
                w_state_nxt      = S_DONE;
                w_done_ok        = 1'b1;
              end
            end
          endcase
        end else if (32'(r_wcnt) + 32'd1 >= TIMEOUT) begin
          w_state_nxt = S_DONE;
          w_done_err  = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction word for the upcoming cycle, registered onto o_cop_instr.
  always_comb begin : instr_build
    w_data      = '0;
    w_opc       = w_op;
    w_instr_nxt = '0;
    case (w_phase_nxt)
      P_STORE_A: begin
        w_opc  = OPC_STORE_A;
        w_data = store_data(w_mat_a, w_pos_nxt);
      end
      P_STORE_B: begin
        w_opc  = OPC_STORE_B;
        w_data = store_data(w_mat_b, w_pos_nxt);
      end
      P_LOAD:  w_opc = OPC_LOAD;
      default: w_opc = w_op;
    endcase
    if (w_state_nxt == S_ISSUE || w_state_nxt == S_WAIT) begin
      w_instr_nxt = {5'b0, w_data, w_opc, w_msize, w_pos_nxt, (w_state_nxt == S_ISSUE)};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_phase     <= P_STORE_A;
      r_pos       <= '0;
      r_op        <= '0;
      r_msize     <= '0;
      r_mat_a     <= '0;
      r_mat_b     <= '0;
      r_wcnt      <= '0;
      r_stage     <= '0;
      r_ovf_stage <= 1'b0;
      o_cop_instr <= '0;
      o_res_valid <= 1'b0;
      o_result    <= '0;
      o_ovf       <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_pos       <= w_pos_nxt;
      r_op        <= w_op;
      r_msize     <= w_msize;
      r_mat_a     <= w_mat_a;
      r_mat_b     <= w_mat_b;
      r_wcnt      <= w_wcnt_nxt;
      r_stage     <= w_stage_nxt;
      r_ovf_stage <= w_ovf_stage_nxt;
      o_cop_instr <= w_instr_nxt;
      o_res_valid <= w_done_ok | w_done_err;
      o_busy      <= (w_state_nxt != S_IDLE);
      o_cmd_ready <= (w_state_nxt == S_IDLE);
      if (w_done_ok) begin
        o_result <= w_stage_nxt;
        o_ovf    <= r_ovf_stage;
        o_err    <= 1'b0;
      end else if (w_done_err) begin
        o_ovf    <= 1'b0;
        o_err    <= 1'b1;
      end
    end
  end

endmodule
